conv_sequencer: RTL and testbench
=================================

# conv_sequencer

Central controller for the 8-tap-x / 4-tap-f convolution datapath: sequences loading of the x and f operand memories through their valid/ready input channels, then walks the memories to drive the multiply-accumulate unit and presents each result on the y output channel. It sits between the three streaming ports and the two single-port memories plus accumulator. The memories have one-cycle read latency, and this block owns all of their address and enable signals.

## Interface
Parameters:
- `N`, 8, x vector length
- `M`, 4, filter length (`M <= N`)
- `LOGN`, 3, x address width
- `LOGM`, 2, f address width

Ports:
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `s_valid_x`  in  1  x input valid
- `s_ready_x`  out  1  x input ready
- `s_valid_f`  in  1  f input valid
- `s_ready_f`  out  1  f input ready
- `m_valid_y`  out  1  result valid
- `m_ready_y`  in  1  result consumer ready
- `addr_x`  out  `LOGN`  x memory address (write address during load, read address during compute)
- `wr_en_x`  out  1  x memory write enable
- `addr_f`  out  `LOGM`  f memory address
- `wr_en_f`  out  1  f memory write enable
- `clr_acc`  out  1  synchronous accumulator clear
- `en_acc`  out  1  accumulator enable (acc += x*f)
- `conv_done`  out  1  one-cycle pulse after the final output of a vector is accepted

## Operation
- States: `LOAD`, `COMPUTE`, `OUTPUT`.
- Reset: state `LOAD`; counters `x_cnt`, `f_cnt`, `base`, `k` are 0; all outputs 0 except `s_ready_x`/`s_ready_f`, which assert after reset deasserts.
- **LOAD**
  - `s_ready_x = (x_cnt < N)`; `wr_en_x = s_valid_x & s_ready_x`; `addr_x = x_cnt`. x and f load independently and concurrently.
  - f uses the same rules with `f_cnt` and `M`.
  - Data presented without valid is never written.
  - When both counters are full, go to `COMPUTE` with `base = 0`, `k = 0`.
- **COMPUTE** (one window per output, `M+1` cycles)
  - Cycle 0: `addr_x = base`, `addr_f = 0`, `clr_acc = 1`.
  - Cycle j, 1 ≤ j < M: `addr_x = base + j`, `addr_f = j`, `en_acc = 1` (consumes the data read in cycle j-1).
  - Cycle M: `en_acc = 1`, no new read.
  - Then go to `OUTPUT`.
- **OUTPUT**
  - `m_valid_y = 1`; hold until `m_ready_y`. The accumulator is frozen (`en_acc = 0`, `clr_acc = 0`).
  - On handshake with `base < N-M`: `base++`, go to `COMPUTE`.
  - On handshake with `base == N-M`: pulse `conv_done`, clear `x_cnt` and `f_cnt`, go to `LOAD`.
- Each vector produces `N-M+1` outputs (5 by default).
- Counter widths: `base` and `x_cnt` are `LOGN+1` bits so the value `N` is representable; `addr_x` never exceeds `N-1`.
- Accumulator width (owned by the datapath) is 18 bits signed for 8-bit operands. This block performs no arithmetic on data.

## Timing
- All outputs are registered except `wr_en_x` and `wr_en_f`, which are combinational from valid & ready.
- `s_ready_x` drops the cycle after the Nth accept. A valid held during the cycle of the Nth accept is not double-written.
- First `m_valid_y` is asserted `M+2` cycles after the cycle in which the last operand is accepted.
- Back-to-back outputs with `m_ready_y` held high are spaced `M+2` cycles apart.
- `m_valid_y` never drops without a handshake. Result data is stable while valid.
- `s_ready_x` and `s_ready_f` are 0 outside `LOAD`. No input is accepted during `COMPUTE` or `OUTPUT`.
- Reset asserted mid-operation: immediately return to `LOAD`, zero all counters, deassert `m_valid_y`, `en_acc`, `wr_en_*`. A partial vector is discarded.

## Configuration
- `CONV_SEQ_FILTER_REUSE_EN`
  - Defined: f is loaded only for the first vector after reset. At the end of a vector only `x_cnt` is cleared, `s_ready_f` stays 0, and `LOAD` exits when x is full.
  - Undefined: both memories reload for every vector, as described in Operation.

## Structure
- Package `conv_seq_pkg`:
  - `typedef enum logic [1:0] {LOAD, COMPUTE, OUTPUT} conv_state_t`
  - default constants `N_DEF = 8`, `M_DEF = 4`
- Sub-module `load_counter` (parameters `SIZE`, `LOGSIZE`; outputs count, ready, wr_en, full), instantiated once for x and once for f.

## Test plan
- x = {10,-20,30,-40,50,60,70,80}, f = {10,20,-30,40}, `m_ready_y` always 1 → y = -2800, 3600, 400, 1600, 2800; `conv_done` pulses once.
- Second vector x = {-90,100,-110,120,-50,40,30,-20}, f = {-50,-60,70,80} with random valid/ready → y = 400, 6000, -2000, 2200, 600; no y after the fifth.
- `m_ready_y = 0` for 10 cycles during `OUTPUT` → `m_valid_y` stays high, `en_acc` stays 0, value unchanged, then accepted once.
- x fully loaded 20 cycles before f → `s_ready_x` low while `s_ready_f` stays high; compute starts exactly `M+2` cycles before the first `m_valid_y`, counted from the last f accept.
- `reset` pulsed low during `COMPUTE` of the third output → `m_valid_y`, `en_acc` = 0 immediately; a full reload then yields the correct 5 outputs.
- With `CONV_SEQ_FILTER_REUSE_EN` defined, second vector sends x only → `s_ready_f` stays 0 and outputs use f = {10,20,-30,40}.

Source files
------------

// File: rtl/conv_seq_pkg.sv
// Shared state encoding and default geometry for the convolution sequencer.
package conv_seq_pkg;

    typedef enum logic [1:0] {LOAD, COMPUTE, OUTPUT} conv_state_t;

    localparam int N_DEF = 8;
    localparam int M_DEF = 4;

endpackage

// File: rtl/load_counter.sv
// Purpose: write-address counter and ready generator for one operand load channel.
// Latency: wr_en is combinational from valid & registered ready; count/full report the post-cycle value.
// Backpressure: ready deasserts the cycle after the SIZE-th accept or whenever LOAD is not next.
module load_counter
    import conv_seq_pkg::*;
#(
    parameter int SIZE    = 8,
    parameter int LOGSIZE = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               valid,
    input  logic               load_nxt,
    input  logic               clr,
    output logic [LOGSIZE:0]   count,
    output logic               ready,
    output logic               wr_en,
    output logic               full
);

    localparam logic [LOGSIZE:0] FULL_CNT = (LOGSIZE+1)'(SIZE);

    logic [LOGSIZE:0] count_q, count_d;
    logic             ready_q;

    assign wr_en = valid & ready_q;
    assign ready = ready_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (wr_en) begin
            count_d = count_q + 1'b1;
        end
    end

    // Next-cycle view lets the controller leave LOAD on the cycle of the last accept.
    assign count = count_d;
    assign full  = (count_d == FULL_CNT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            ready_q <= 1'b0;
        end else begin
            count_q <= count_d;
            ready_q <= load_nxt && (count_d < FULL_CNT);
        end
    end

endmodule

// File: rtl/conv_sequencer.sv
// Purpose: sequences x/f operand loads, MAC windows and y handshakes for the convolution datapath.
// Latency: first y valid M+2 cycles after the last operand accept; windows repeat every M+2 cycles.
// Backpressure: y held valid (accumulator frozen) until m_ready_y; inputs refused outside LOAD.
// CONV_SEQ_FILTER_REUSE_EN: keep the filter loaded after the first vector and reload only x.
module conv_sequencer
    import conv_seq_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int M    = M_DEF,
    parameter int LOGN = 3,
    parameter int LOGM = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_valid_x,
    output logic            s_ready_x,
    input  logic            s_valid_f,
    output logic            s_ready_f,
    output logic            m_valid_y,
    input  logic            m_ready_y,
    output logic [LOGN-1:0] addr_x,
    output logic            wr_en_x,
    output logic [LOGM-1:0] addr_f,
    output logic            wr_en_f,
    output logic            clr_acc,
    output logic            en_acc,
    output logic            conv_done
);

    localparam logic [LOGN:0]   X_FULL    = (LOGN+1)'(N);
    localparam logic [LOGN-1:0] X_LAST    = LOGN'(N-1);
    localparam logic [LOGM:0]   F_FULL    = (LOGM+1)'(M);
    localparam logic [LOGM-1:0] F_LAST    = LOGM'(M-1);
    localparam logic [LOGN:0]   LAST_BASE = (LOGN+1)'(N-M);
    localparam logic [LOGM:0]   K_LAST    = (LOGM+1)'(M);

    conv_state_t     state_q, state_d;
    logic [LOGN:0]   base_q, base_d;
    logic [LOGM:0]   k_q, k_d;
    logic [LOGN:0]   x_cnt, rd_idx;
    logic [LOGM:0]   f_cnt;
    logic            x_full, f_full, cnt_clr, f_clr, load_nxt;
    logic [LOGN-1:0] addr_x_q, addr_x_d;
    logic [LOGM-1:0] addr_f_q, addr_f_d;
    logic            clr_acc_q, en_acc_q, m_valid_q, done_q;

    assign cnt_clr  = (state_q == OUTPUT) && m_ready_y && (base_q == LAST_BASE);
    assign load_nxt = (state_d == LOAD);

`ifdef CONV_SEQ_FILTER_REUSE_EN
    assign f_clr = 1'b0;
`else
    assign f_clr = cnt_clr;
`endif

    load_counter #(.SIZE(N), .LOGSIZE(LOGN)) u_x_cnt (
        .clk      (clk),
        .reset    (reset),
        .valid    (s_valid_x),
        .load_nxt (load_nxt),
        .clr      (cnt_clr),
        .count    (x_cnt),
        .ready    (s_ready_x),
        .wr_en    (wr_en_x),
        .full     (x_full)
    );

    load_counter #(.SIZE(M), .LOGSIZE(LOGM)) u_f_cnt (
        .clk      (clk),
        .reset    (reset),
        .valid    (s_valid_f),
        .load_nxt (load_nxt),
        .clr      (f_clr),
        .count    (f_cnt),
        .ready    (s_ready_f),
        .wr_en    (wr_en_f),
        .full     (f_full)
    );

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        k_d     = k_q;
        case (state_q)
            LOAD: begin
                if (x_full && f_full) begin
                    state_d = COMPUTE;
                    base_d  = '0;
                    k_d     = '0;
                end
            end
            COMPUTE: begin
                if (k_q == K_LAST) begin
                    state_d = OUTPUT;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            OUTPUT: begin
                if (m_ready_y) begin
                    if (base_q == LAST_BASE) begin
                        state_d = LOAD;
                        base_d  = '0;
                    end else begin
                        state_d = COMPUTE;
                        base_d  = base_q + 1'b1;
                        k_d     = '0;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    assign rd_idx = base_d + (LOGN+1)'(k_d);

    always_comb begin
        addr_x_d = addr_x_q;
        addr_f_d = addr_f_q;
        case (state_d)
            LOAD: begin
                addr_x_d = (x_cnt >= X_FULL) ? X_LAST : x_cnt[LOGN-1:0];
                addr_f_d = (f_cnt >= F_FULL) ? F_LAST : f_cnt[LOGM-1:0];
            end
            COMPUTE: begin
                if (k_d != K_LAST) begin
                    addr_x_d = rd_idx[LOGN-1:0];
                    addr_f_d = k_d[LOGM-1:0];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= LOAD;
            base_q    <= '0;
            k_q       <= '0;
            addr_x_q  <= '0;
            addr_f_q  <= '0;
            clr_acc_q <= 1'b0;
            en_acc_q  <= 1'b0;
            m_valid_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            k_q       <= k_d;
            addr_x_q  <= addr_x_d;
            addr_f_q  <= addr_f_d;
            clr_acc_q <= (state_d == COMPUTE) && (k_d == '0);
            en_acc_q  <= (state_d == COMPUTE) && (k_d != '0);
            m_valid_q <= (state_d == OUTPUT);
            done_q    <= cnt_clr;
        end
    end

    assign addr_x    = addr_x_q;
    assign addr_f    = addr_f_q;
    assign clr_acc   = clr_acc_q;
    assign en_acc    = en_acc_q;
    assign m_valid_y = m_valid_q;
    assign conv_done = done_q;

endmodule

// File: tb/tb_conv_sequencer.sv
// Bench for conv_sequencer: behavioural memories and accumulator around the DUT, scoreboarded y results.
module tb_conv_sequencer;
    import conv_seq_pkg::*;

    localparam int N = 8, M = 4, LOGN = 3, LOGM = 2, NOUT = N - M + 1;

    typedef struct packed {
        logic [N-1:0][7:0]     x;
        logic [M-1:0][7:0]     f;
        logic                  send_f;
        logic                  rnd;
        logic [NOUT-1:0][31:0] y;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic s_valid_x, s_ready_x, s_valid_f, s_ready_f;
    logic m_valid_y, m_ready_y;
    logic [LOGN-1:0] addr_x;
    logic [LOGM-1:0] addr_f;
    logic wr_en_x, wr_en_f, clr_acc, en_acc, conv_done;
    logic [7:0] x_dat, f_dat;

    always #5 clk = ~clk;

    conv_sequencer #(.N(N), .M(M), .LOGN(LOGN), .LOGM(LOGM)) dut (
        .clk       (clk),
        .reset     (reset),
        .s_valid_x (s_valid_x),
        .s_ready_x (s_ready_x),
        .s_valid_f (s_valid_f),
        .s_ready_f (s_ready_f),
        .m_valid_y (m_valid_y),
        .m_ready_y (m_ready_y),
        .addr_x    (addr_x),
        .wr_en_x   (wr_en_x),
        .addr_f    (addr_f),
        .wr_en_f   (wr_en_f),
        .clr_acc   (clr_acc),
        .en_acc    (en_acc),
        .conv_done (conv_done)
    );

    // Datapath: single-port memories with one-cycle read, 18-bit signed accumulator.
    logic [7:0] xmem [N];
    logic [7:0] fmem [M];
    logic signed [7:0]  rd_x, rd_f;
    logic signed [17:0] acc;

    always @(posedge clk) begin
        if (wr_en_x) xmem[addr_x] <= x_dat;
        if (wr_en_f) fmem[addr_f] <= f_dat;
        rd_x <= xmem[addr_x];
        rd_f <= fmem[addr_f];
        if (clr_acc)     acc <= '0;
        else if (en_acc) acc <= acc + rd_x * rd_f;
    end

    int checks = 0, errors = 0;
    int exp_q[$];
    int out_cnt = 0, done_cnt = 0, exp_v = 0;
    int rdy_mode = 0;
    time t_last = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // m_ready_y driver: 0 = held low, 1 = held high, 2 = random.
    initial begin
        m_ready_y = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       m_ready_y = 1'b0;
                1:       m_ready_y = 1'b1;
                default: m_ready_y = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Output monitor and scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            if (conv_done) done_cnt++;
            if (m_valid_y && m_ready_y) begin
                out_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL y_unexpected: got %0d expected no output", int'(acc));
                end else begin
                    exp_v = exp_q.pop_front();
                    chk("y_value", int'(acc), exp_v);
                end
            end
            if (en_acc || clr_acc || m_valid_y)
                chk("ready_low_outside_load", int'(s_ready_x | s_ready_f), 0);
        end
    end

    task automatic send_ch(input bit is_f, input vec_t v);
        int n = is_f ? M : N;
        int g;
        for (int i = 0; i < n; i++) begin
            if (v.rnd) begin
                if (is_f) begin s_valid_f = 1'b0; f_dat = 8'h5A; end
                else      begin s_valid_x = 1'b0; x_dat = 8'hA5; end
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
            if (is_f) begin s_valid_f = 1'b1; f_dat = v.f[i]; end
            else      begin s_valid_x = 1'b1; x_dat = v.x[i]; end
            g = 0;
            while (!(is_f ? s_ready_f : s_ready_x) && g < 300) begin
                @(posedge clk); #1;
                g++;
            end
            if (g >= 300) begin
                fail(is_f ? "f_ready_wait" : "x_ready_wait");
                break;
            end
            @(posedge clk);
            t_last = $time;
            #1;
        end
        if (is_f) begin s_valid_f = 1'b0; f_dat = 8'h5A; end
        else      begin s_valid_x = 1'b0; x_dat = 8'hA5; end
    endtask

    task automatic load_vec(input vec_t v);
        fork
            send_ch(1'b0, v);
            if (v.send_f) send_ch(1'b1, v);
        join
    endtask

    task automatic push_exp(input vec_t v);
        for (int i = 0; i < NOUT; i++) exp_q.push_back($signed(v.y[i]));
    endtask

    task automatic wait_drain(input string name);
        int g = 0;
        while (exp_q.size() != 0 && g < 3000) begin
            @(negedge clk); #1;
            g++;
        end
        if (g >= 3000) fail(name);
        repeat (3 * (M + 2)) @(negedge clk);
        #1;
    endtask

    int X1[N] = '{10, -20, 30, -40, 50, 60, 70, 80};
    int F1[M] = '{10, 20, -30, 40};
    int Y1[NOUT] = '{-2800, 3600, 400, 1600, 2800};
    int X2[N] = '{-90, 100, -110, 120, -50, 40, 30, -20};
    int F2[M] = '{-50, -60, 70, 80};
`ifdef CONV_SEQ_FILTER_REUSE_EN
    int Y2[NOUT] = '{9200, -6800, 4400, 200, -1400};
    localparam bit SEND_F_AGAIN = 1'b0;
`else
    int Y2[NOUT] = '{400, 6000, -2000, 2200, 600};
    localparam bit SEND_F_AGAIN = 1'b1;
`endif

    function automatic vec_t mk(input int xs[N], input int fs[M], input bit sf, input bit rnd,
                                input int ys[NOUT]);
        vec_t v;
        for (int i = 0; i < N; i++)    v.x[i] = 8'(xs[i]);
        for (int i = 0; i < M; i++)    v.f[i] = 8'(fs[i]);
        for (int i = 0; i < NOUT; i++) v.y[i] = 32'(ys[i]);
        v.send_f = sf;
        v.rnd    = rnd;
        return v;
    endfunction

    vec_t tbl[2];
    vec_t va;
    int   d0, n, bad, held, o0, g;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        s_valid_x = 1'b0; s_valid_f = 1'b0;
        x_dat = 8'hA5; f_dat = 8'h5A;
        rdy_mode = 0;
        va     = mk(X1, F1, 1'b1, 1'b0, Y1);
        tbl[0] = mk(X1, F1, SEND_F_AGAIN, 1'b0, Y1);
        tbl[1] = mk(X2, F2, SEND_F_AGAIN, 1'b1, Y2);

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_m_valid", int'(m_valid_y), 0);
        chk("rst_ready_x", int'(s_ready_x), 0);
        chk("rst_ready_f", int'(s_ready_f), 0);
        chk("rst_acc_ctl", int'({en_acc, clr_acc, conv_done}), 0);
        chk("rst_addr", int'({addr_x, addr_f}), 0);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_ready_x", int'(s_ready_x), 1);
        chk("post_rst_ready_f", int'(s_ready_f), 1);
        chk("post_rst_wr_en", int'({wr_en_x, wr_en_f}), 0);

        // x loaded well before f, first output stalled by the consumer.
        d0 = done_cnt;
        push_exp(va);
        @(posedge clk); #1;
        send_ch(1'b0, va);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (s_ready_x || !s_ready_f || m_valid_y || en_acc || clr_acc) bad++;
        end
        chk("x_full_wait_for_f", bad, 0);
        @(posedge clk); #1;
        send_ch(1'b1, va);
        @(negedge clk);
        n = 1;
        chk("compute_start_clr", int'(clr_acc), 1);
        chk("compute_start_addr", int'({addr_x, addr_f}), 0);
        while (!m_valid_y && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("first_valid_latency", n, M + 2);
        held = int'(acc);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (!m_valid_y || en_acc || clr_acc || int'(acc) != held) bad++;
        end
        chk("stall_hold", bad, 0);
        rdy_mode = 1;
        wait_drain("drain_stall_vec");
        chk("done_pulse_stall_vec", done_cnt - d0, 1);

        // Table-driven vectors.
        for (int t = 0; t < 2; t++) begin
            d0 = done_cnt;
            rdy_mode = tbl[t].rnd ? 2 : 1;
            push_exp(tbl[t]);
            @(posedge clk); #1;
            chk("f_ready_at_load", int'(s_ready_f), int'(tbl[t].send_f));
            chk("x_ready_at_load", int'(s_ready_x), 1);
            load_vec(tbl[t]);
            wait_drain("drain_table_vec");
            chk("done_pulse_table_vec", done_cnt - d0, 1);
        end

        // Reset during the third output's window, then a full reload.
        rdy_mode = 1;
        push_exp(va);
        @(posedge clk); #1;
        load_vec(va);
        o0 = out_cnt;
        g = 0;
        while (out_cnt - o0 < 2 && g < 500) begin @(negedge clk); #1; g++; end
        if (g >= 500) fail("wait_two_outputs");
        g = 0;
        while (!en_acc && g < 20) begin @(negedge clk); g++; end
        if (g >= 20) fail("wait_third_window");
        #1 reset = 1'b0;
        #1;
        chk("midrst_m_valid", int'(m_valid_y), 0);
        chk("midrst_en_acc", int'(en_acc), 0);
        chk("midrst_ready", int'({s_ready_x, s_ready_f}), 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        d0 = done_cnt;
        push_exp(va);
        @(posedge clk); #1;
        load_vec(va);
        wait_drain("drain_after_reset");
        chk("done_pulse_after_reset", done_cnt - d0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
